// File: rtl/data_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter_if
//
// Purpose:
//   Groups the two masters' single-word req/ack handshakes and the shared
//   data-bus address/mode lines that the arbiter sequences.
//
// Signals:
//   mN_req / mN_we / mN_addr / mN_wdata : master N request and payload
//   mN_ack                              : one-cycle completion pulse
//   mN_rdata                            : read data returned to master N
//   data_bus_addr / data_bus_mode       : shared bus address and mode
//
// Modports:
//   master : the arbiter's view. It takes the requests and masters the
//            shared bus.
//   slave  : the environment's view. This covers the requesting masters and
//            the bus slaves that watch addr/mode.
//
// The tri-state data_bus_data net is not part of this interface. It stays a
// plain inout on the arbiter so that it resolves as an ordinary wire.
// -----------------------------------------------------------------------------
interface data_bus_arbiter_if;

  // Master 0: core load/store unit
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic [31:0] m0_rdata;

  // Master 1: debug/DMA port
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic [31:0] m1_rdata;

  // Shared bus control
  logic [31:0] data_bus_addr;
  logic [1:0]  data_bus_mode;

  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output data_bus_addr, data_bus_mode
  );

  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  data_bus_addr, data_bus_mode
  );

endinterface

// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
//
// Purpose:
//   Two-master arbiter and sequencer for the shared data bus.
//   - Master 0 is the core load/store unit.
//   - Master 1 is the debug/DMA port.
//   Each granted single-word transaction is turned into the bus timing that
//   the slaves need:
//   - read:  mode 01 held for READ_SETUP_CYCLES setup cycles plus one
//            capture cycle, with the data sampled on the capture edge;
//   - write: a single mode 10 cycle with the write data driven.
//   Simultaneous requests are resolved round-robin.
//
// Parameters:
//   READ_SETUP_CYCLES : setup cycles before the capture cycle (legal 1..7)
//   IDLE_MODE         : bus mode driven when no transaction is active
//
// Ports:
//   clk           : system clock, all state on the rising edge
//   reset         : asynchronous, active-high reset
//   bus           : master/slave handshakes plus bus addr/mode (master modport)
//   data_bus_data : tri-state bus data. It is driven only in WRITE and is
//                   high-Z otherwise.
//
// Every output is decoded from registered state alone. No request input
// reaches the bus or an ack combinationally.
// -----------------------------------------------------------------------------
module data_bus_arbiter #(
  parameter int unsigned READ_SETUP_CYCLES = 1,
  parameter logic [1:0]  IDLE_MODE         = 2'b00
) (
  input  logic                 clk,
  input  logic                 reset,
  data_bus_arbiter_if.master   bus,
  inout  wire  [31:0]          data_bus_data
);

  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  // Value loaded into the setup counter on a read grant. READ_SETUP counts
  // down to zero, so it lasts READ_SETUP_CYCLES cycles.
  localparam logic [2:0] SETUP_LOAD = 3'(READ_SETUP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_SETUP,
    S_READ_CAPTURE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e      state_q,      state_d;
  logic [2:0]  cnt_q,        cnt_d;
  logic        grant_q,      grant_d;       // id of the master being served
  logic        last_grant_q, last_grant_d;  // id of the most recent grant
  logic        we_q,         we_d;
  logic [31:0] addr_q,       addr_d;
  logic [31:0] wdata_q,      wdata_d;
  logic [31:0] m0_rdata_q,   m0_rdata_d;
  logic [31:0] m1_rdata_q,   m1_rdata_d;

  // Arbitration result for the current IDLE cycle
  logic        pick_id;
  logic        pick_we;
  logic [31:0] pick_addr;
  logic [31:0] pick_wdata;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;   // master 0 wins the first tie
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      m0_rdata_q   <= 32'd0;
      m1_rdata_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick. A lone requester always wins. On a tie, the master that
  // was not granted last wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    pick_id = (bus.m0_req && bus.m1_req) ? ~last_grant_q : bus.m1_req;
    if (pick_id) begin
      pick_we    = bus.m1_we;
      pick_addr  = bus.m1_addr;
      pick_wdata = bus.m1_wdata;
    end else begin
      pick_we    = bus.m0_we;
      pick_addr  = bus.m0_addr;
      pick_wdata = bus.m0_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets its hold value before the case statement. An
  // unassigned path in combinational logic would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          // Latch the payload. The master may drop req after this point and
          // the transaction still runs to completion.
          grant_d      = pick_id;
          last_grant_d = pick_id;
          we_d         = pick_we;
          addr_d       = pick_addr;
          wdata_d      = pick_wdata;
          if (pick_we) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ_SETUP;
            cnt_d   = SETUP_LOAD;
          end
        end
      end

      S_READ_SETUP: begin
        if (cnt_q == 3'd0) begin
          state_d = S_READ_CAPTURE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_READ_CAPTURE: begin
        // The slave drives the bus while mode is 01. Sample it at this edge.
        if (grant_q) begin
          m1_rdata_d = data_bus_data;
        end else begin
          m0_rdata_d = data_bus_data;
        end
        state_d = S_DONE;
      end

      S_WRITE: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        // Requests are deliberately not sampled here. A waiting master is
        // evaluated in the next IDLE cycle.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  logic bus_read_phase;
  logic bus_write_phase;

  assign bus_read_phase  = (state_q == S_READ_SETUP) || (state_q == S_READ_CAPTURE);
  assign bus_write_phase = (state_q == S_WRITE);

  assign bus.data_bus_mode = bus_read_phase  ? MODE_READ  :
                             bus_write_phase ? MODE_WRITE : IDLE_MODE;

  assign bus.data_bus_addr = (bus_read_phase || bus_write_phase) ? addr_q : 32'd0;

  // Drive only in WRITE. Slaves drive only while mode is 01, so the two
  // drivers never overlap.
  assign data_bus_data = bus_write_phase ? wdata_q : 32'bz;

  assign bus.m0_ack   = (state_q == S_DONE) && !grant_q;
  assign bus.m1_ack   = (state_q == S_DONE) &&  grant_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;

  // we_q is latched for clarity of the transaction record. The state already
  // encodes the direction, so this keeps the bit referenced.
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_bus_arbiter
//
// Self-checking bench for data_bus_arbiter. It drives directed scenarios and
// then randomized request mixes. Expected values come from a transaction-level
// reference model:
//   - an associative memory image;
//   - the round-robin rule;
//   - the latency formulas.
// Inputs are driven on the falling edge and outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_data_bus_arbiter;

  localparam int         RSC       = 1;
  localparam int         RSC3      = 3;
  localparam logic [1:0] IDLE_MODE = 2'b00;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_bus_arbiter_if bif ();
  data_bus_arbiter_if bif3 ();
  wire [31:0] bus_data;
  wire [31:0] bus_data3;

  data_bus_arbiter #(.READ_SETUP_CYCLES(RSC), .IDLE_MODE(IDLE_MODE)) dut (
    .clk(clk), .reset(reset), .bus(bif.master), .data_bus_data(bus_data)
  );

  data_bus_arbiter #(.READ_SETUP_CYCLES(RSC3), .IDLE_MODE(IDLE_MODE)) dut3 (
    .clk(clk), .reset(reset), .bus(bif3.master), .data_bus_data(bus_data3)
  );

  // Bus slave for the main DUT. It is a word memory indexed by the low
  // address bits.
  logic [31:0] mem [256] = '{default: 32'h0};
  assign bus_data = (bif.data_bus_mode == 2'b01) ? mem[bif.data_bus_addr[9:2]] : 32'bz;
  always @(posedge clk) begin
    if (bif.data_bus_mode == 2'b10) mem[bif.data_bus_addr[9:2]] <= bus_data;
  end

  // Bus slave for the second DUT. It returns a fixed function of the address.
  assign bus_data3 = (bif3.data_bus_mode == 2'b01) ? (bif3.data_bus_addr ^ 32'hA5A5_A5A5) : 32'bz;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] ref_mem [logic [31:0]];
  int          ref_last = 1;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic int ref_pick(input bit r0, input bit r1);
    int w;
    if (r0 && r1) w = 1 - ref_last;
    else          w = r1 ? 1 : 0;
    ref_last = w;
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  task automatic drive(input int who, input txn_t t);
    if (who == 0) begin
      bif.m0_we = t.we; bif.m0_addr = t.addr; bif.m0_wdata = t.wdata; bif.m0_req = 1'b1;
    end else begin
      bif.m1_we = t.we; bif.m1_addr = t.addr; bif.m1_wdata = t.wdata; bif.m1_req = 1'b1;
    end
  endtask

  task automatic drop(input int who);
    if (who == 0) bif.m0_req = 1'b0;
    else          bif.m1_req = 1'b0;
  endtask

  function automatic logic ack_of(input int who);
    return (who == 0) ? bif.m0_ack : bif.m1_ack;
  endfunction

  function automatic logic [31:0] rdata_of(input int who);
    return (who == 0) ? bif.m0_rdata : bif.m1_rdata;
  endfunction

  // Serve one transaction of master `who`. The caller sits on a falling edge
  // whose cycle index is k0. Index 1 is the IDLE cycle in which req is
  // sampled.
  task automatic serve(input int who, input txn_t t, input int k0, input string tag);
    int          k, lat, n_rd, n_wr;
    bit          got, dbl;
    logic [31:0] exp_rd, wr_a, wr_d, rd_a;
    lat    = t.we ? 3 : 3 + RSC;
    exp_rd = ref_read(t.addr);
    k = k0; got = 0; dbl = 0; n_rd = 0; n_wr = 0;
    wr_a = '0; wr_d = '0; rd_a = '0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (bif.data_bus_mode == 2'b01) begin n_rd++; rd_a = bif.data_bus_addr; end
      if (bif.data_bus_mode == 2'b10) begin n_wr++; wr_a = bif.data_bus_addr; wr_d = bus_data; end
      if (bif.m0_ack && bif.m1_ack) dbl = 1;
      if (bif.m0_ack || bif.m1_ack) got = 1;
    end
    check({tag, "/ack_m", (who == 0) ? "0" : "1"}, {31'd0, ack_of(who)}, 32'd1);
    check({tag, "/latency"}, k, lat);
    check({tag, "/double_ack"}, {31'd0, dbl}, 32'd0);
    if (t.we) begin
      check({tag, "/write_cycles"}, n_wr, 1);
      check({tag, "/write_addr"}, wr_a, t.addr);
      check({tag, "/write_data"}, wr_d, t.wdata);
      ref_mem[t.addr] = t.wdata;
    end else begin
      check({tag, "/read_cycles"}, n_rd, RSC + 1);
      check({tag, "/read_addr"}, rd_a, t.addr);
      check({tag, "/rdata"}, rdata_of(who), exp_rd);
    end
    drop(who);
  endtask

  // Raise the selected requests in one IDLE cycle and serve them in the
  // order the round-robin rule predicts.
  task automatic run_txns(input bit r0, input bit r1, input txn_t t0, input txn_t t1, input string tag);
    txn_t t [2];
    bit   r [2];
    int   who, k0;
    t[0] = t0; t[1] = t1; r[0] = r0; r[1] = r1;
    @(negedge clk);
    if (r0) drive(0, t0);
    if (r1) drive(1, t1);
    k0 = 1;
    for (int n = 0; n < 2; n++) begin
      if (r[0] || r[1]) begin
        who = ref_pick(r[0], r[1]);
        serve(who, t[who], k0, tag);
        r[who] = 0;
        k0 = 0;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_last = 1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          k, n_rd;
    bit          stray;
    int          sel;
    txn_t        ta, tb;

    reset = 1'b1;
    bif.m0_req = 0; bif.m0_we = 0; bif.m0_addr = 0; bif.m0_wdata = 0;
    bif.m1_req = 0; bif.m1_we = 0; bif.m1_addr = 0; bif.m1_wdata = 0;
    bif3.m0_req = 0; bif3.m0_we = 0; bif3.m0_addr = 0; bif3.m0_wdata = 0;
    bif3.m1_req = 0; bif3.m1_we = 0; bif3.m1_addr = 0; bif3.m1_wdata = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset/mode", {30'd0, bif.data_bus_mode}, {30'd0, IDLE_MODE});
    check("reset/addr", bif.data_bus_addr, 32'd0);
    check("reset/m0_ack", {31'd0, bif.m0_ack}, 32'd0);
    check("reset/m1_ack", {31'd0, bif.m1_ack}, 32'd0);
    check("reset/m0_rdata", bif.m0_rdata, 32'd0);
    check("reset/m1_rdata", bif.m1_rdata, 32'd0);
    reset = 1'b0;

    // Single write, then read back, with rdata held after the ack
    run_txns(1, 0, mk(1, 32'h2004, 32'hDEADBEEF), mk(0, 0, 0), "m0_write");
    run_txns(1, 0, mk(0, 32'h2004, 32'h0), mk(0, 0, 0), "m0_read");
    @(negedge clk);
    check("m0_read/rdata_held", bif.m0_rdata, 32'hDEADBEEF);

    // Tie right after reset: master 0 first, master 1 reads its data
    apply_reset();
    run_txns(1, 1, mk(1, 32'h2000, 32'h11111111), mk(0, 32'h2000, 32'h0), "tie_after_reset");

    // Back-to-back ties alternate grants
    for (int i = 0; i < 3; i++) begin
      run_txns(1, 1, mk(1, 32'h2010 + 32'(4 * i), 32'hA0000000 + 32'(i)),
                     mk(0, 32'h2010 + 32'(4 * i), 32'h0), "alternate");
    end

    // Longer read setup on the second instance
    @(negedge clk);
    bif3.m1_we = 1'b0; bif3.m1_addr = 32'h3010; bif3.m1_req = 1'b1;
    k = 1; n_rd = 0; stray = 0;
    while (!bif3.m1_ack && k < 40) begin
      @(negedge clk);
      k++;
      if (bif3.data_bus_mode == 2'b01) n_rd++;
      if (bif3.m0_ack) stray = 1;
    end
    check("rsc3/ack_cycle", k, 6);
    check("rsc3/read_cycles", n_rd, 4);
    check("rsc3/rdata", bif3.m1_rdata, 32'h3010 ^ 32'hA5A5_A5A5);
    check("rsc3/m0_ack", {31'd0, stray}, 32'd0);
    bif3.m1_req = 1'b0;

    // Asynchronous reset between edges while in READ_SETUP
    @(negedge clk);
    drive(0, mk(0, 32'h2004, 32'h0));
    @(negedge clk);
    check("abort/in_setup", {30'd0, bif.data_bus_mode}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort/mode", {30'd0, bif.data_bus_mode}, {30'd0, IDLE_MODE});
    check("abort/addr", bif.data_bus_addr, 32'd0);
    check("abort/m0_ack", {31'd0, bif.m0_ack}, 32'd0);
    check("abort/m0_rdata", bif.m0_rdata, 32'd0);
    bif.m0_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ref_last = 1;
    run_txns(1, 0, mk(0, 32'h2004, 32'h0), mk(0, 0, 0), "after_abort");

    // Randomized request mixes against the reference model
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(1, 3));
      ta = mk(1'($urandom_range(0, 1)), 32'h2000 + 32'(4 * $urandom_range(0, 15)), $urandom);
      tb = mk(1'($urandom_range(0, 1)), 32'h2000 + 32'(4 * $urandom_range(0, 15)), $urandom);
      run_txns(sel[0], sel[1], ta, tb, "random");
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
